// File: rtl/cache_refill_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cache_refill_ctrl_pkg                                      |
// | Description : Shared geometry, FSM encoding and address helpers for the  |
// |               instruction-cache refill controller.                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package cache_refill_ctrl_pkg;

  localparam int LINE_BEATS  = 8;
  localparam int BEAT_W      = 32;
  localparam int LINE_BITS   = LINE_BEATS * BEAT_W;
  localparam int IDX_W       = 3;
  localparam int TAG_W       = 4;
  localparam int OFS_W       = 5;
  localparam int CNT_W       = $clog2(LINE_BEATS);
  localparam int LINE_ADDR_W = 32 - OFS_W;
  localparam int SETS        = 1 << IDX_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FILL  = 2'd2,
    WRITE = 2'd3
  } state_t;

  // Cache index of a fetch address (pc[7:5]).
  function automatic logic [IDX_W-1:0] pc_index(input logic [31:0] pc);
    return pc[OFS_W +: IDX_W];
  endfunction

  // Cache tag of a fetch address (pc[11:8]).
  function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc);
    return pc[OFS_W+IDX_W +: TAG_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_refill_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cache_refill_ctrl_if                                       |
// | Description : Fetch, memory and cache-write signals of the refill        |
// |               controller. master = controller, slave = its environment.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface cache_refill_ctrl_if;
  import cache_refill_ctrl_pkg::*;

  // fetch side
  logic [31:0]          pcOut;
  logic                 fetch_valid;
  logic                 hit;
  logic                 hit_way;
  logic                 stall;
  // memory side
  logic                 mem_req;
  logic [31:0]          mem_addr;
  logic                 mem_gnt;
  logic                 mem_rvalid;
  logic [31:0]          mem_rdata;
  // cache write side
  logic                 regWrite_set0;
  logic                 regWrite_set1;
  logic [IDX_W-1:0]     fill_index;
  logic [TAG_W-1:0]     fill_tag;
  logic                 fill_viv;
  logic [LINE_BITS-1:0] fill_data;

  modport master (
    input  pcOut, fetch_valid, hit, hit_way, mem_gnt, mem_rvalid, mem_rdata,
    output stall, mem_req, mem_addr, regWrite_set0, regWrite_set1,
           fill_index, fill_tag, fill_viv, fill_data
  );

  modport slave (
    output pcOut, fetch_valid, hit, hit_way, mem_gnt, mem_rvalid, mem_rdata,
    input  stall, mem_req, mem_addr, regWrite_set0, regWrite_set1,
           fill_index, fill_tag, fill_viv, fill_data
  );

endinterface
`default_nettype wire

// File: rtl/cache_refill_ctrl_line_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cache_refill_ctrl_line_buffer                              |
// | Description : Refill line buffer: 8 x 32-bit beat slots written in       |
// |               arrival order, beat counter and last-beat flag.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cache_refill_ctrl_line_buffer
  import cache_refill_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 beat_we,
  input  logic [BEAT_W-1:0]    beat_data,
  output logic                 last_beat,
  output logic [LINE_BITS-1:0] line_data
);

  logic [CNT_W-1:0]                   r_cnt;
  logic [LINE_BEATS-1:0][BEAT_W-1:0]  r_beats;

  // Beat counter: restarts when a new line is granted, advances per accepted beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (beat_we) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Beat storage: the current count selects the slot, so beat k lands at [32k+31:32k].
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_beats <= '0;
    end else if (beat_we) begin
      r_beats[r_cnt] <= beat_data;
    end
  end

  assign last_beat = (r_cnt == CNT_W'(LINE_BEATS - 1));
  assign line_data = r_beats;

endmodule
`default_nettype wire

// File: rtl/cache_refill_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cache_refill_ctrl                                          |
// | Description : Miss handler for a 2-way, 8-index instruction cache.       |
// |               Stalls fetch on a miss, reads the 32B line as 8 beats,     |
// |               writes it once into the LRU victim way, owns the LRU bits. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cache_refill_ctrl
  import cache_refill_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  cache_refill_ctrl_if.master bus
);

  state_t                 r_state;
  state_t                 w_next;
  logic [LINE_ADDR_W-1:0] r_line;
  logic [IDX_W-1:0]       r_idx;
  logic [TAG_W-1:0]       r_tag;
  logic                   r_victim;
  logic [SETS-1:0]        r_lru;

  logic [IDX_W-1:0]       w_idx;
  logic [TAG_W-1:0]       w_tag;
  logic                   w_take_hit;
  logic                   w_take_miss;
  logic                   w_buf_clear;
  logic                   w_beat_we;
  logic                   w_last_beat;
  logic [LINE_BITS-1:0]   w_line_data;

  assign w_idx       = pc_index(bus.pcOut);
  assign w_tag       = pc_tag(bus.pcOut);
  // Fetch inputs only matter while idle; during a refill the latched request rules.
  assign w_take_hit  = (r_state == IDLE) && bus.fetch_valid &&  bus.hit;
  assign w_take_miss = (r_state == IDLE) && bus.fetch_valid && !bus.hit;

  cache_refill_ctrl_line_buffer u_line_buffer (
    .clk       (clk),
    .reset     (reset),
    .clear     (w_buf_clear),
    .beat_we   (w_beat_we),
    .beat_data (bus.mem_rdata),
    .last_beat (w_last_beat),
    .line_data (w_line_data)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state plus handshake/strobe outputs; stall rises in the miss cycle itself.
  always_comb begin
    w_next            = r_state;
    w_buf_clear       = 1'b0;
    w_beat_we         = 1'b0;
    bus.stall         = 1'b0;
    bus.mem_req       = 1'b0;
    bus.mem_addr      = '0;
    bus.regWrite_set0 = 1'b0;
    bus.regWrite_set1 = 1'b0;
    bus.fill_viv      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_take_miss) begin
          bus.stall = 1'b1;
          w_next    = REQ;
        end
      end
      REQ: begin
        bus.stall    = 1'b1;
        bus.mem_req  = 1'b1;
        bus.mem_addr = {r_line, {OFS_W{1'b0}}};
        if (bus.mem_gnt) begin
          w_buf_clear = 1'b1;
          w_next      = FILL;
        end
      end
      FILL: begin
        bus.stall = 1'b1;
        if (bus.mem_rvalid) begin
          w_beat_we = 1'b1;
          if (w_last_beat) begin
            w_next = WRITE;
          end
        end
      end
      WRITE: begin
        bus.stall         = 1'b1;
        bus.fill_viv      = 1'b1;
        bus.regWrite_set0 = !r_victim;
        bus.regWrite_set1 =  r_victim;
        w_next            = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
    // The miss-cycle stall is combinational from fetch inputs; hold it low in reset.
    if (!reset) begin
      bus.stall = 1'b0;
    end
  end

  // Latch the missing request so later fetch activity cannot disturb the refill.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_line   <= '0;
      r_idx    <= '0;
      r_tag    <= '0;
      r_victim <= 1'b0;
    end else if (w_take_miss) begin
      r_line   <= bus.pcOut[31:OFS_W];
      r_idx    <= w_idx;
      r_tag    <= w_tag;
      r_victim <= r_lru[w_idx];
    end
  end

  // LRU bit per index names the victim way: a hit or a fill makes the other way victim.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lru <= '0;
    end else if (w_take_hit) begin
      r_lru[w_idx] <= !bus.hit_way;
    end else if (r_state == WRITE) begin
      r_lru[r_idx] <= !r_victim;
    end
  end

  assign bus.fill_index = r_idx;
  assign bus.fill_tag   = r_tag;
  assign bus.fill_data  = w_line_data;

endmodule
`default_nettype wire
